imm_encoder: RTL and testbench

//  Inverse of the datapath immediate decoder: takes an instruction skeleton plus a 32-bit

---
 rtl/imm_encoder.sv | 157 +++++++++++++++
 tb/tb_imm_encoder.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_encoder.sv
// imm_encoder: builds RV32I program words from an instruction skeleton and a
// signed immediate. The immediate is range-checked against the format implied by
// the opcode, scattered into the instruction's immediate fields, and presented
// through a single registered valid/ready stage together with a running byte
// address and saturating good/bad word counters.
module imm_encoder #(
  parameter int          ADDR_W    = 10,
  parameter int unsigned BASE_ADDR = 0,
  parameter int          CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_base,
  input  logic [31:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_err,
  output logic [CNT_W-1:0]  cnt_ok,
  output logic [CNT_W-1:0]  cnt_err
);

  // Opcodes that carry an immediate this block knows how to place.
  typedef enum logic [6:0] {
    OP_LOAD   = 7'd3,
    OP_OPIMM  = 7'd19,
    OP_STORE  = 7'd35,
    OP_BRANCH = 7'd99,
    OP_JAL    = 7'd111
  } opcode_e;

  // Substituted for the whole word whenever encoding fails (addi x0,x0,0).
  localparam logic [31:0]       NOP_INSTR = 32'h0000_0013;
  localparam logic [ADDR_W-1:0] ADDR_BASE = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(4);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

  // Bits [31:25] of the skeleton always fall inside an immediate field for the
  // supported formats, so they never reach the output.
  logic base_unused;
  assign base_unused = ^in_base[31:25];

  // Handshake
  logic accept;
  logic xfer;

  assign in_ready = ~out_valid | out_ready;
  assign accept   = in_valid & in_ready;
  assign xfer     = out_valid & out_ready;

  // Range checks: every bit above the field MSB must replicate the sign bit.
  logic fits_12;  // I/S: imm[11] is the sign bit
  logic fits_13;  // B:   imm[12] is the sign bit
  logic fits_21;  // J:   imm[20] is the sign bit

  assign fits_12 = (&in_imm[31:11]) | ~(|in_imm[31:11]);
  assign fits_13 = (&in_imm[31:12]) | ~(|in_imm[31:12]);
  assign fits_21 = (&in_imm[31:20]) | ~(|in_imm[31:20]);

  logic [31:0] enc_instr;
  logic        enc_err;

  // Scatter the immediate into the fields selected by the opcode.
  always_comb begin
    // NOTE: defaults first so every path assigns every output; otherwise a latch is inferred.
    enc_instr = NOP_INSTR;
    enc_err   = 1'b1;
    case (in_base[6:0])
      OP_LOAD, OP_OPIMM: begin
        if (fits_12) begin
          enc_instr = {in_imm[11:0], in_base[19:0]};
          enc_err   = 1'b0;
        end
      end
      OP_STORE: begin
        if (fits_12) begin
          enc_instr = {in_imm[11:5], in_base[24:12], in_imm[4:0], in_base[6:0]};
          enc_err   = 1'b0;
        end
      end
      OP_BRANCH: begin
        if (fits_13 && !in_imm[0]) begin
          enc_instr = {in_imm[12], in_imm[10:5], in_base[24:12],
                       in_imm[4:1], in_imm[11], in_base[6:0]};
          enc_err   = 1'b0;
        end
      end
      OP_JAL: begin
        if (fits_21 && !in_imm[0]) begin
          enc_instr = {in_imm[20], in_imm[10:1], in_imm[11],
                       in_imm[19:12], in_base[11:0]};
          enc_err   = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Address to hand to the next loaded word. A transfer in this cycle already
  // consumes the current address, so a back-to-back load gets the advanced one;
  // clr overrides both.
  logic [ADDR_W-1:0] next_addr;
  logic [ADDR_W-1:0] addr_eff;

  always_comb begin
    addr_eff = next_addr;
    if (clr) begin
      addr_eff = ADDR_BASE;
    end else if (xfer) begin
      addr_eff = next_addr + ADDR_STEP;
    end
  end

  // Output register stage and running address.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_instr <= 32'h0;
      out_err   <= 1'b0;
      out_addr  <= ADDR_BASE;
      next_addr <= ADDR_BASE;
    end else begin
      next_addr <= addr_eff;
      if (accept) begin
        out_valid <= 1'b1;
        out_instr <= enc_instr;
        out_err   <= enc_err;
        out_addr  <= addr_eff;
      end else if (xfer) begin
        out_valid <= 1'b0;
      end
    end
  end

  // Saturating counters of transferred good and bad words.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_ok  <= '0;
      cnt_err <= '0;
    end else if (clr) begin
      cnt_ok  <= '0;
      cnt_err <= '0;
    end else if (xfer) begin
      if (out_err) begin
        if (cnt_err != CNT_MAX) cnt_err <= cnt_err + 1'b1;
      end else begin
        if (cnt_ok != CNT_MAX) cnt_ok <= cnt_ok + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_imm_encoder.sv
// Testbench for imm_encoder: directed vectors with hand-computed encodings,
// a field-decode round trip, backpressure, reset mid-transfer, and a small
// instance for address wrap, counter saturation and clear.
module tb_imm_encoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default-parameter instance
  logic        rst_n, clr, in_valid, in_ready, out_valid, out_ready, out_err;
  logic [31:0] in_base, in_imm, out_instr;
  logic [9:0]  out_addr;
  logic [15:0] cnt_ok, cnt_err;

  // Small instance: ADDR_W=4, BASE_ADDR=4, CNT_W=2
  logic        s_clr, s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_out_err;
  logic [31:0] s_in_base, s_in_imm, s_out_instr;
  logic [3:0]  s_out_addr;
  logic [1:0]  s_cnt_ok, s_cnt_err;

  imm_encoder dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready), .in_base(in_base), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_addr(out_addr), .out_err(out_err), .cnt_ok(cnt_ok), .cnt_err(cnt_err)
  );

  imm_encoder #(.ADDR_W(4), .BASE_ADDR(4), .CNT_W(2)) dut_s (
    .clk(clk), .rst_n(rst_n), .clr(s_clr),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_base(s_in_base), .in_imm(s_in_imm),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_instr(s_out_instr),
    .out_addr(s_out_addr), .out_err(s_out_err), .cnt_ok(s_cnt_ok), .cnt_err(s_cnt_err)
  );

  int vecs = 0;
  int miscompares = 0;

  // Bench-side model of the running address and counters of the main instance
  logic [9:0] exp_addr;
  int         exp_ok;
  int         exp_err;

  typedef struct {
    logic [31:0] base;
    logic [31:0] imm;
    logic [31:0] instr;
    logic        err;
  } vec_t;

  task automatic drive_word(input logic [31:0] b, input logic [31:0] i);
    in_base   = b;
    in_imm    = i;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid  = 1'b0;
  endtask

  task automatic model_xfer(input logic e);
    exp_addr = exp_addr + 10'd4;
    if (e) exp_err++;
    else   exp_ok++;
  endtask

  // Immediate as an RV32I decoder would reconstruct it
  function automatic logic [31:0] decode_imm(input logic [31:0] w);
    case (w[6:0])
      7'd35:   decode_imm = {{20{w[31]}}, w[31:25], w[11:7]};
      7'd99:   decode_imm = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      7'd111:  decode_imm = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
      default: decode_imm = {{20{w[31]}}, w[31:20]};
    endcase
  endfunction

  function automatic logic [31:0] imm_mask(input logic [6:0] op);
    case (op)
      7'd35, 7'd99: imm_mask = 32'hFE00_0F80;
      7'd111:       imm_mask = 32'hFFFF_F000;
      default:      imm_mask = 32'hFFF0_0000;
    endcase
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_base = 32'h0; in_imm = 32'h0;
    s_clr = 1'b0; s_in_valid = 1'b0; s_out_ready = 1'b1;
    s_in_base = 32'h0; s_in_imm = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    vecs++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    vecs++; if (out_instr !== 32'h0) begin miscompares++; $display("FAIL reset_out_instr got=%h exp=00000000", out_instr); end
    vecs++; if (out_err !== 1'b0) begin miscompares++; $display("FAIL reset_out_err got=%b exp=0", out_err); end
    vecs++; if (out_addr !== 10'd0) begin miscompares++; $display("FAIL reset_out_addr got=%0d exp=0", out_addr); end
    vecs++; if (cnt_ok !== 16'd0 || cnt_err !== 16'd0) begin miscompares++; $display("FAIL reset_counters got=%0d/%0d exp=0/0", cnt_ok, cnt_err); end
    vecs++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    vecs++; if (s_out_addr !== 4'd4) begin miscompares++; $display("FAIL reset_small_addr got=%0d exp=4", s_out_addr); end
    rst_n = 1'b1;
    exp_addr = 10'd0; exp_ok = 0; exp_err = 0;
  endtask

  task automatic test_directed();
    vec_t tbl [17];
    tbl = '{
      '{32'h0000_0513, 32'hFFFF_FFFF, 32'hFFF0_0513, 1'b0},  // I imm=-1
      '{32'h0000_2083, 32'hFFFF_F800, 32'h8000_2083, 1'b0},  // I imm=-2048
      '{32'h0000_0513, 32'hFFFF_F7FF, 32'h0000_0013, 1'b1},  // I imm=-2049
      '{32'h0020_2023, 32'h0000_07FF, 32'h7E20_2FA3, 1'b0},  // S imm=2047
      '{32'h0020_2023, 32'h0000_0800, 32'h0000_0013, 1'b1},  // S imm=2048
      '{32'h0020_2023, 32'hFFFF_F800, 32'h8020_2023, 1'b0},  // S imm=-2048
      '{32'h0020_2023, 32'hFFFF_F7FF, 32'h0000_0013, 1'b1},  // S imm=-2049
      '{32'h0000_0063, 32'hFFFF_F000, 32'h8000_0063, 1'b0},  // B imm=-4096
      '{32'h0000_0063, 32'h0000_0003, 32'h0000_0013, 1'b1},  // B odd
      '{32'h0000_0063, 32'h0000_0FFE, 32'h7E00_0FE3, 1'b0},  // B imm=4094
      '{32'h0000_0063, 32'h0000_1000, 32'h0000_0013, 1'b1},  // B imm=4096
      '{32'h0000_0063, 32'hFFFF_EFFE, 32'h0000_0013, 1'b1},  // B imm=-4098
      '{32'h0000_006F, 32'h0000_0800, 32'h0010_006F, 1'b0},  // J imm=2048
      '{32'h0000_006F, 32'hFFF0_0000, 32'h8000_006F, 1'b0},  // J imm=-1048576
      '{32'h0000_006F, 32'h000F_FFFE, 32'h7FFF_F06F, 1'b0},  // J imm=1048574
      '{32'h0000_006F, 32'h0010_0000, 32'h0000_0013, 1'b1},  // J imm=1048576
      '{32'h0000_0037, 32'h0000_0000, 32'h0000_0013, 1'b1}   // LUI unsupported
    };
    for (int k = 0; k < 17; k++) begin
      drive_word(tbl[k].base, tbl[k].imm);
      vecs++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL dir%0d_valid got=%b exp=1", k, out_valid); end
      vecs++; if (out_instr !== tbl[k].instr) begin miscompares++; $display("FAIL dir%0d_instr got=%h exp=%h", k, out_instr, tbl[k].instr); end
      vecs++; if (out_err !== tbl[k].err) begin miscompares++; $display("FAIL dir%0d_err got=%b exp=%b", k, out_err, tbl[k].err); end
      vecs++; if (out_addr !== exp_addr) begin miscompares++; $display("FAIL dir%0d_addr got=%0d exp=%0d", k, out_addr, exp_addr); end
      @(posedge clk); #1;
      model_xfer(tbl[k].err);
      vecs++; if (cnt_ok !== 16'(exp_ok) || cnt_err !== 16'(exp_err)) begin
        miscompares++; $display("FAIL dir%0d_counters got=%0d/%0d exp=%0d/%0d", k, cnt_ok, cnt_err, exp_ok, exp_err);
      end
    end
  endtask

  task automatic test_roundtrip();
    logic [6:0]  ops [5];
    logic [31:0] b, i, m;
    ops = '{7'd3, 7'd19, 7'd35, 7'd99, 7'd111};
    for (int o = 0; o < 5; o++) begin
      for (int n = 0; n < 100; n++) begin
        case (o)
          3:       i = 32'($urandom_range(0, 4095)) * 2 - 32'd4096;
          4:       i = 32'($urandom_range(0, 1048575)) * 2 - 32'd1048576;
          default: i = 32'($urandom_range(0, 4095)) - 32'd2048;
        endcase
        b = {$urandom()};
        b[6:0] = ops[o];
        m = imm_mask(ops[o]);
        drive_word(b, i);
        vecs++; if (out_err !== 1'b0 || decode_imm(out_instr) !== i) begin
          miscompares++; $display("FAIL rt_op%0d_imm got=%h err=%b exp=%h", ops[o], decode_imm(out_instr), out_err, i);
        end
        vecs++; if ((out_instr & ~m) !== (b & ~m)) begin
          miscompares++; $display("FAIL rt_op%0d_base got=%h exp=%h", ops[o], out_instr & ~m, b & ~m);
        end
        vecs++; if (out_addr !== exp_addr) begin miscompares++; $display("FAIL rt_addr got=%0d exp=%0d", out_addr, exp_addr); end
        @(posedge clk); #1;
        model_xfer(1'b0);
      end
    end
    vecs++; if (cnt_ok !== 16'(exp_ok) || cnt_err !== 16'(exp_err)) begin
      miscompares++; $display("FAIL rt_counters got=%0d/%0d exp=%0d/%0d", cnt_ok, cnt_err, exp_ok, exp_err);
    end
  endtask

  task automatic test_back_to_back();
    logic [9:0] a_addr;
    out_ready = 1'b0;
    in_base   = 32'h0000_0513;
    in_imm    = 32'd5;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    a_addr = exp_addr;
    in_imm = 32'd6;
    for (int c = 0; c < 3; c++) begin
      vecs++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL bp%0d_in_ready got=%b exp=0", c, in_ready); end
      vecs++; if (out_valid !== 1'b1 || out_instr !== 32'h0050_0513 || out_addr !== a_addr) begin
        miscompares++; $display("FAIL bp%0d_hold got=%b/%h/%0d exp=1/00500513/%0d", c, out_valid, out_instr, out_addr, a_addr);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    #1;
    vecs++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL bp_release_in_ready got=%b exp=1", in_ready); end
    @(posedge clk); #1;
    model_xfer(1'b0);
    vecs++; if (out_instr !== 32'h0060_0513 || out_addr !== exp_addr) begin
      miscompares++; $display("FAIL b2b_word1 got=%h@%0d exp=00600513@%0d", out_instr, out_addr, exp_addr);
    end
    in_imm = 32'd7;
    @(posedge clk); #1;
    model_xfer(1'b0);
    vecs++; if (out_instr !== 32'h0070_0513 || out_addr !== exp_addr) begin
      miscompares++; $display("FAIL b2b_word2 got=%h@%0d exp=00700513@%0d", out_instr, out_addr, exp_addr);
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    model_xfer(1'b0);
    vecs++; if (out_valid !== 1'b0 || cnt_ok !== 16'(exp_ok)) begin
      miscompares++; $display("FAIL b2b_drain got=%b/%0d exp=0/%0d", out_valid, cnt_ok, exp_ok);
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    in_base   = 32'h0000_0513;
    in_imm    = 32'd1;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst_n    = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    vecs++; if (out_valid !== 1'b0 || out_addr !== 10'd0) begin
      miscompares++; $display("FAIL rstmid_state got=%b@%0d exp=0@0", out_valid, out_addr);
    end
    vecs++; if (cnt_ok !== 16'd0 || cnt_err !== 16'd0) begin
      miscompares++; $display("FAIL rstmid_counters got=%0d/%0d exp=0/0", cnt_ok, cnt_err);
    end
    exp_addr = 10'd0; exp_ok = 0; exp_err = 0;
    out_ready = 1'b1;
  endtask

  task automatic test_wrap_saturate();
    logic [3:0] addrs [5];
    logic [1:0] oks [5];
    addrs = '{4'd4, 4'd8, 4'd12, 4'd0, 4'd4};
    oks   = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    for (int k = 0; k < 5; k++) begin
      s_in_base   = 32'h0000_0513;
      s_in_imm    = 32'(k);
      s_in_valid  = 1'b1;
      s_out_ready = 1'b1;
      @(posedge clk); #1;
      s_in_valid = 1'b0;
      vecs++; if (s_out_addr !== addrs[k]) begin miscompares++; $display("FAIL wrap%0d_addr got=%0d exp=%0d", k, s_out_addr, addrs[k]); end
      @(posedge clk); #1;
      vecs++; if (s_cnt_ok !== oks[k]) begin miscompares++; $display("FAIL sat%0d_cnt_ok got=%0d exp=%0d", k, s_cnt_ok, oks[k]); end
    end
  endtask

  task automatic test_clr();
    s_out_ready = 1'b0;
    s_in_base   = 32'h0000_0513;
    s_in_imm    = 32'd9;
    s_in_valid  = 1'b1;
    @(posedge clk); #1;
    s_in_valid = 1'b0;
    vecs++; if (s_out_valid !== 1'b1 || s_out_addr !== 4'd8) begin
      miscompares++; $display("FAIL clr_presented got=%b@%0d exp=1@8", s_out_valid, s_out_addr);
    end
    s_out_ready = 1'b1;
    s_clr       = 1'b1;
    @(posedge clk); #1;
    s_clr = 1'b0;
    vecs++; if (s_out_valid !== 1'b0 || s_cnt_ok !== 2'd0 || s_cnt_err !== 2'd0) begin
      miscompares++; $display("FAIL clr_state got=%b %0d/%0d exp=0 0/0", s_out_valid, s_cnt_ok, s_cnt_err);
    end
    for (int k = 0; k < 4; k++) begin
      s_in_base  = 32'h0000_0037;
      s_in_imm   = 32'd0;
      s_in_valid = 1'b1;
      @(posedge clk); #1;
      s_in_valid = 1'b0;
      if (k == 0) begin
        vecs++; if (s_out_addr !== 4'd4 || s_out_err !== 1'b1 || s_out_instr !== 32'h0000_0013) begin
          miscompares++; $display("FAIL clr_next_word got=%0d/%b/%h exp=4/1/00000013", s_out_addr, s_out_err, s_out_instr);
        end
      end
      @(posedge clk); #1;
    end
    vecs++; if (s_cnt_err !== 2'd3 || s_cnt_ok !== 2'd0) begin
      miscompares++; $display("FAIL err_saturate got=%0d/%0d exp=0/3", s_cnt_ok, s_cnt_err);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_roundtrip();
    test_back_to_back();
    test_reset_mid();
    test_wrap_saturate();
    test_clr();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end

endmodule
